// File: rtl/lcd_bus_pkg.sv
// Shared definitions for the character-LCD bus receiver: FSM states, HD44780 opcodes,
// DDRAM wrap points and the address step helper.
package lcd_bus_pkg;

  typedef logic [2:0] lcd_state_t;

  localparam lcd_state_t S_INIT0 = 3'd0;
  localparam lcd_state_t S_INIT1 = 3'd1;
  localparam lcd_state_t S_INIT2 = 3'd2;
  localparam lcd_state_t S_INIT3 = 3'd3;
  localparam lcd_state_t S_HI    = 3'd4;
  localparam lcd_state_t S_LO    = 3'd5;

  localparam logic [7:0] CMD_CLEAR      = 8'h01;
  localparam logic [7:0] CMD_HOME       = 8'h02;
  localparam logic [7:0] CMD_SET_DDRAM  = 8'h80;
  localparam logic [7:0] CMD_ENTRY_MODE = 8'h04;

  localparam logic [6:0] ADDR_ZERO    = 7'h00;
  localparam logic [6:0] LINE0_END    = 7'h27;
  localparam logic [6:0] LINE1_START  = 7'h40;
  localparam logic [6:0] LINE1_END    = 7'h67;
  localparam logic [6:0] ONE_LINE_END = 7'h4F;

  function automatic logic [6:0] addr_step(input logic [6:0] a, input logic inc,
                                           input logic two_line);
    logic [6:0] r;
    if (inc) begin
      if (two_line && a == LINE0_END) r = LINE1_START;
      else if (two_line && a == LINE1_END) r = ADDR_ZERO;
      else if (!two_line && a == ONE_LINE_END) r = ADDR_ZERO;
      else r = a + 7'd1;
    end else begin
      if (a == ADDR_ZERO) r = two_line ? LINE1_END : ONE_LINE_END;
      else if (two_line && a == LINE1_START) r = LINE0_END;
      else r = a - 7'd1;
    end
    return r;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/lcd_bus_receiver_ddram_addr.sv
// DDRAM address tracker: decodes address-affecting commands, latches the entry-mode
// I/D bit and advances the address after every data write.
module lcd_ddram_addr
  import lcd_bus_pkg::*;
#(
  parameter int TWO_LINE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       byte_valid,
  input  logic       byte_rs,
  input  logic [7:0] byte_value,
  output logic [6:0] address
);

  localparam logic TWO_LINE_BIT = (TWO_LINE != 0);

  logic inc;

  // Address and I/D latch; I/D comes out of reset as increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      address <= 7'h00;
      inc     <= 1'b1;
    end else if (byte_valid) begin
      if (byte_rs) begin
        address <= addr_step(address, inc, TWO_LINE_BIT);
      end else if ((byte_value & CMD_SET_DDRAM) == CMD_SET_DDRAM) begin
        address <= byte_value[6:0];
      end else if ((byte_value & 8'hFC) == CMD_ENTRY_MODE) begin
        inc <= byte_value[1];
      end else if (byte_value == CMD_CLEAR || (byte_value & 8'hFE) == CMD_HOME) begin
        address <= ADDR_ZERO;
      end else begin
        address <= address;
      end
    end else begin
      address <= address;
    end
  end

endmodule

// File: rtl/lcd_bus_receiver.sv
// Passive receiver for the 4-bit character-LCD bus. Optional E/setup timing checks are
// compiled in when LCD_TIMING_CHECK_EN is defined.
module lcd_bus_receiver
  import lcd_bus_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int E_HIGH_MIN = (CLK_HZ / 1_000_000 * 230 + 999) / 1000,
  parameter int SETUP_MIN  = (CLK_HZ / 1_000_000 * 40 + 999) / 1000,
  parameter int TWO_LINE   = 1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iLCD_Enabled,
  input  logic       iLCD_RegisterSelect,
  input  logic       iLCD_ReadWrite,
  input  logic       iLCD_StrataFlashControl,
  input  logic [3:0] iLCD_Data,
  output logic [7:0] oByte,
  output logic       oByteRS,
  output logic       oByteValid,
  output logic [6:0] oAddress,
  output logic       oInitDone,
  output logic       oProtocolError
);

  lcd_state_t state, state_next;
  logic       e_q;
  logic [3:0] hi_nib;
  logic       hi_rs;
  logic       fall, accept, rw_err, timing_err;
  logic       byte_fire, hi_load, init_fire, err_fsm;
  logic [7:0] byte_value;

  assign fall       = e_q & ~iLCD_Enabled & iLCD_StrataFlashControl;
  assign accept     = fall & ~iLCD_ReadWrite;
  assign rw_err     = fall & iLCD_ReadWrite;
  assign byte_value = {hi_nib, iLCD_Data};

  // FSM state register.
  always_ff @(posedge Clock) begin
    if (Reset) state <= S_INIT0;
    else       state <= state_next;
  end

  // Next state: only accepted falls (flash released, write cycle) move the FSM.
  always_comb begin
    state_next = state;
    if (accept) begin
      case (state)
        S_INIT0: state_next = (iLCD_Data == 4'h3) ? S_INIT1 : S_INIT0;
        S_INIT1: state_next = (iLCD_Data == 4'h3) ? S_INIT2 : S_INIT0;
        S_INIT2: state_next = (iLCD_Data == 4'h3) ? S_INIT3 : S_INIT0;
        S_INIT3: state_next = (iLCD_Data == 4'h2) ? S_HI : S_INIT0;
        S_HI:    state_next = S_LO;
        S_LO:    state_next = S_HI;
        default: state_next = S_INIT0;
      endcase
    end else begin
      state_next = state;
    end
  end

  // Per-fall actions decoded from the current state.
  always_comb begin
    byte_fire = 1'b0;
    hi_load   = 1'b0;
    init_fire = 1'b0;
    err_fsm   = rw_err;
    if (accept) begin
      case (state)
        S_INIT0, S_INIT1, S_INIT2: err_fsm = (iLCD_Data != 4'h3);
        S_INIT3: begin
          err_fsm   = (iLCD_Data != 4'h2);
          init_fire = (iLCD_Data == 4'h2);
        end
        S_HI: hi_load = 1'b1;
        S_LO: begin
          byte_fire = (iLCD_RegisterSelect == hi_rs);
          err_fsm   = (iLCD_RegisterSelect != hi_rs);
        end
        default: err_fsm = 1'b1;
      endcase
    end else begin
      byte_fire = 1'b0;
    end
  end

  // Registered outputs, E history and the held high nibble.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      e_q            <= 1'b0;
      hi_nib         <= 4'h0;
      hi_rs          <= 1'b0;
      oByte          <= 8'h00;
      oByteRS        <= 1'b0;
      oByteValid     <= 1'b0;
      oInitDone      <= 1'b0;
      oProtocolError <= 1'b0;
    end else begin
      e_q        <= iLCD_Enabled;
      oByteValid <= byte_fire;
      if (hi_load) begin
        hi_nib <= iLCD_Data;
        hi_rs  <= iLCD_RegisterSelect;
      end
      if (byte_fire) begin
        oByte   <= byte_value;
        oByteRS <= iLCD_RegisterSelect;
      end
      if (init_fire) oInitDone <= 1'b1;
      if (err_fsm || timing_err) oProtocolError <= 1'b1;
    end
  end

`ifdef LCD_TIMING_CHECK_EN
  logic [7:0] e_high_cnt, stable_cnt;
  logic [5:0] bus, bus_q;

  assign bus = {iLCD_RegisterSelect, iLCD_ReadWrite, iLCD_Data};

  // Saturating E-high width and bus-stable counters.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      e_high_cnt <= 8'd0;
      stable_cnt <= 8'd0;
      bus_q      <= 6'd0;
    end else begin
      e_high_cnt <= iLCD_Enabled ? sat_inc(e_high_cnt) : 8'd0;
      stable_cnt <= (bus == bus_q) ? sat_inc(stable_cnt) : 8'd0;
      bus_q      <= bus;
    end
  end

  assign timing_err = iLCD_StrataFlashControl &
                      ((e_q & ~iLCD_Enabled & (e_high_cnt < 8'(E_HIGH_MIN))) |
                       (~e_q & iLCD_Enabled & (stable_cnt < 8'(SETUP_MIN))) |
                       (e_q & iLCD_Enabled & (bus != bus_q)));
`else
  logic unused_timing;
  assign unused_timing = ^{E_HIGH_MIN, SETUP_MIN};
  assign timing_err    = 1'b0;
`endif

  lcd_ddram_addr #(.TWO_LINE(TWO_LINE)) u_addr (
    .clk       (Clock),
    .reset     (Reset),
    .byte_valid(byte_fire),
    .byte_rs   (iLCD_RegisterSelect),
    .byte_value(byte_value),
    .address   (oAddress)
  );

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Self-checking bench for lcd_bus_receiver: directed scenarios plus a randomized byte stream
// checked against a linear-cursor model of the two-line DDRAM.
module tb_lcd_bus_receiver;

  logic       clk = 1'b0;
  logic       rst, e, rs, rw, flash;
  logic [3:0] data;
  logic [7:0] o_byte;
  logic       o_rs, o_valid, o_init, o_err;
  logic [6:0] o_addr;

  int checks = 0;
  int failures = 0;

  typedef struct { logic rs; logic [7:0] b; logic [6:0] a; } obs_t;
  obs_t obs_q[$];
  obs_t o;

  int model_pos;
  bit model_inc;

  always #5 clk = ~clk;

  lcd_bus_receiver dut (
    .Clock(clk), .Reset(rst), .iLCD_Enabled(e), .iLCD_RegisterSelect(rs),
    .iLCD_ReadWrite(rw), .iLCD_StrataFlashControl(flash), .iLCD_Data(data),
    .oByte(o_byte), .oByteRS(o_rs), .oByteValid(o_valid), .oAddress(o_addr),
    .oInitDone(o_init), .oProtocolError(o_err)
  );

  // every cycle the valid flag is seen high records one output byte
  always @(negedge clk) begin
    if (o_valid === 1'b1) obs_q.push_back('{o_rs, o_byte, o_addr});
  end

  // cursor position 0..79 over the two 40-character lines
  function automatic logic [6:0] addr_of(input int pos);
    return (pos < 40) ? 7'(pos) : 7'(pos + 24);
  endfunction

  task automatic model_reset();
    model_pos = 0;
    model_inc = 1'b1;
  endtask

  task automatic model_apply(input logic m_rs, input logic [7:0] b);
    if (m_rs) model_pos = model_inc ? (model_pos + 1) % 80 : (model_pos + 79) % 80;
    else if (b[7]) model_pos = (b[6:0] < 7'h40) ? int'(b[6:0]) : int'(b[6:0]) - 24;
    else if (b == 8'h01 || b == 8'h02 || b == 8'h03) model_pos = 0;
    else if (b[7:2] == 6'd1) model_inc = b[1];
  endtask

  task automatic send_nibble(input logic n_rs, input logic n_rw, input logic n_flash,
                             input logic [3:0] n_data, input int high, input int setup);
    rs = n_rs; rw = n_rw; flash = n_flash; data = n_data; e = 1'b0;
    repeat (setup) @(negedge clk);
    e = 1'b1;
    repeat (high) @(negedge clk);
    e = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic b_rs, input logic [7:0] b);
    logic [7:0] v;
    v = b;
    send_nibble(b_rs, 1'b0, 1'b1, v[7:4], 15, 4);
    send_nibble(b_rs, 1'b0, 1'b1, v[3:0], 15, 4);
  endtask

  task automatic do_init();
    send_nibble(1'b0, 1'b0, 1'b1, 4'h3, 15, 4);
    send_nibble(1'b0, 1'b0, 1'b1, 4'h3, 15, 4);
    send_nibble(1'b0, 1'b0, 1'b1, 4'h3, 15, 4);
    send_nibble(1'b0, 1'b0, 1'b1, 4'h2, 15, 4);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; e = 1'b0; rs = 1'b0; rw = 1'b0; flash = 1'b1; data = 4'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    model_reset();
    obs_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({o_byte, o_rs, o_valid, o_addr, o_init, o_err} !== 19'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {o_byte, o_rs, o_valid, o_addr, o_init, o_err});
    end
  endtask

  task automatic test_init();
    do_init();
    checks++;
    if (o_init !== 1'b1) begin failures++; $display("FAIL init_done got=%b exp=1", o_init); end
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL init_no_byte got=%0d exp=0", obs_q.size()); end
    checks++;
    if (o_err !== 1'b0) begin failures++; $display("FAIL init_no_err got=%b exp=0", o_err); end
  endtask

  task automatic test_first_data();
    send_byte(1'b1, 8'h41);
    model_apply(1'b1, 8'h41);
    checks++;
    if (obs_q.size() != 1) begin failures++; $display("FAIL a_count got=%0d exp=1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      checks++;
      if ({o.rs, o.b, o.a} !== {1'b1, 8'h41, 7'h01})
        begin failures++; $display("FAIL a_byte got=%b/%h/%h exp=1/41/01", o.rs, o.b, o.a); end
    end
    obs_q.delete();
  endtask

  task automatic test_wrap();
    logic [7:0] seq_b[3];
    logic       seq_rs[3];
    logic [6:0] seq_a[3];
    seq_b = '{8'hA7, 8'h5A, 8'h01};
    seq_rs = '{1'b0, 1'b1, 1'b0};
    seq_a = '{7'h27, 7'h40, 7'h00};
    for (int i = 0; i < 3; i++) begin
      send_byte(seq_rs[i], seq_b[i]);
      model_apply(seq_rs[i], seq_b[i]);
      checks++;
      if (obs_q.size() != 1) begin failures++; $display("FAIL wrap_count%0d got=%0d exp=1", i, obs_q.size()); end
      if (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        checks++;
        if ({o.rs, o.b, o.a} !== {seq_rs[i], seq_b[i], seq_a[i]})
          begin failures++; $display("FAIL wrap_step%0d got=%b/%h/%h exp=%b/%h/%h", i, o.rs, o.b, o.a, seq_rs[i], seq_b[i], seq_a[i]); end
      end
      obs_q.delete();
    end
  endtask

  task automatic test_random_stream();
    logic [7:0] b;
    logic       b_rs;
    int         kind;
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 9);
      b_rs = 1'b0;
      if (kind <= 4) begin b_rs = 1'b1; b = 8'($urandom_range(32, 126)); end
      else if (kind == 5) b = 8'h80 | {1'b0, addr_of($urandom_range(0, 79))};
      else if (kind == 6) b = 8'h04 | 8'($urandom_range(0, 3));
      else if (kind == 7) b = 8'($urandom_range(1, 3));
      else b = 8'($urandom_range(8, 63));
      send_byte(b_rs, b);
      model_apply(b_rs, b);
      checks++;
      if (obs_q.size() != 1) begin failures++; $display("FAIL rand_count%0d got=%0d exp=1", i, obs_q.size()); end
      if (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        checks++;
        if ({o.rs, o.b, o.a} !== {b_rs, b, addr_of(model_pos)})
          begin failures++; $display("FAIL rand_byte%0d got=%b/%h/%h exp=%b/%h/%h", i, o.rs, o.b, o.a, b_rs, b, addr_of(model_pos)); end
      end
      obs_q.delete();
    end
    checks++;
    if (o_err !== 1'b0) begin failures++; $display("FAIL rand_no_err got=%b exp=0", o_err); end
  endtask

  task automatic test_flash_ignore();
    send_nibble(1'b1, 1'b0, 1'b0, 4'h9, 15, 4);
    send_byte(1'b1, 8'h6B);
    model_apply(1'b1, 8'h6B);
    checks++;
    if (obs_q.size() != 1) begin failures++; $display("FAIL flash_count got=%0d exp=1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      checks++;
      if ({o.rs, o.b, o.a} !== {1'b1, 8'h6B, addr_of(model_pos)})
        begin failures++; $display("FAIL flash_byte got=%b/%h/%h exp=1/6b/%h", o.rs, o.b, o.a, addr_of(model_pos)); end
    end
    obs_q.delete();
    checks++;
    if (o_err !== 1'b0) begin failures++; $display("FAIL flash_no_err got=%b exp=0", o_err); end
  endtask

  task automatic test_rw_error();
    send_nibble(1'b1, 1'b1, 1'b1, 4'h7, 15, 4);
    checks++;
    if (o_err !== 1'b1) begin failures++; $display("FAIL rw_err got=%b exp=1", o_err); end
    send_byte(1'b1, 8'h33);
    model_apply(1'b1, 8'h33);
    checks++;
    if (obs_q.size() != 1 || obs_q[0].b !== 8'h33 || obs_q[0].a !== addr_of(model_pos))
      begin failures++; $display("FAIL rw_next_byte got_n=%0d exp=1 byte 33", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_rs_mismatch();
    do_reset();
    do_init();
    send_nibble(1'b1, 1'b0, 1'b1, 4'h4, 15, 4);
    send_nibble(1'b0, 1'b0, 1'b1, 4'h1, 15, 4);
    checks++;
    if (o_err !== 1'b1 || obs_q.size() != 0)
      begin failures++; $display("FAIL rs_mismatch got=%b/%0d exp=1/0", o_err, obs_q.size()); end
    send_byte(1'b1, 8'h58);
    checks++;
    if (obs_q.size() != 1 || obs_q[0].b !== 8'h58 || obs_q[0].a !== 7'h01)
      begin failures++; $display("FAIL rs_mismatch_next got_n=%0d exp=1 byte 58 addr 01", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_bad_init();
    do_reset();
    send_nibble(1'b0, 1'b0, 1'b1, 4'h3, 15, 4);
    send_nibble(1'b0, 1'b0, 1'b1, 4'h3, 15, 4);
    send_nibble(1'b0, 1'b0, 1'b1, 4'h5, 15, 4);
    checks++;
    if (o_err !== 1'b1 || o_init !== 1'b0)
      begin failures++; $display("FAIL bad_init got=%b/%b exp=1/0", o_err, o_init); end
    do_init();
    checks++;
    if (o_init !== 1'b1) begin failures++; $display("FAIL reinit got=%b exp=1", o_init); end
  endtask

  task automatic test_reset_mid_byte();
    send_nibble(1'b1, 1'b0, 1'b1, 4'hF, 15, 4);
    do_reset();
    checks++;
    if (o_init !== 1'b0 || o_addr !== 7'h00 || o_err !== 1'b0)
      begin failures++; $display("FAIL mid_reset got=%b/%h/%b exp=0/00/0", o_init, o_addr, o_err); end
    do_init();
    send_byte(1'b1, 8'h42);
    checks++;
    if (obs_q.size() != 1 || obs_q[0].b !== 8'h42 || obs_q[0].a !== 7'h01)
      begin failures++; $display("FAIL mid_reset_byte got_n=%0d exp=1 byte 42 addr 01", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_timing();
    logic exp_err;
`ifdef LCD_TIMING_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    do_reset();
    do_init();
    send_nibble(1'b1, 1'b0, 1'b1, 4'h4, 5, 4);
    checks++;
    if (o_err !== exp_err) begin failures++; $display("FAIL short_e got=%b exp=%b", o_err, exp_err); end
  endtask

  initial begin
    rst = 1'b1; e = 1'b0; rs = 1'b0; rw = 1'b0; flash = 1'b1; data = 4'h0;
    model_reset();
    test_reset();
    test_init();
    test_first_data();
    test_wrap();
    test_random_stream();
    test_flash_ignore();
    test_rw_error();
    test_rs_mismatch();
    test_bad_init();
    test_reset_mid_byte();
    test_timing();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
